// File: rtl/iir_bank_readout_if.sv
// Sample-write and snapshot-readout bus of iir_bank_readout.
// The slave modport is the filter bank; the master modport is the producer/consumer side.
interface iir_bank_readout_if #(
    parameter int N    = 16,
    parameter int BINS = 24
);
    localparam int BW = (BINS > 1) ? $clog2(BINS) : 1;

    logic signed [N-1:0]  in;
    logic        [BW-1:0] inBin;
    logic                 write;
    logic                 start;
    logic signed [N-1:0]  outData;
    logic        [BW-1:0] outBin;
    logic                 outValid;
    logic                 outReady;
    logic                 outLast;
    logic                 busy;

    modport master (
        output in, inBin, write, start, outReady,
        input  outData, outBin, outValid, outLast, busy
    );

    modport slave (
        input  in, inBin, write, start, outReady,
        output outData, outBin, outValid, outLast, busy
    );
endinterface

// File: rtl/iir_bank_readout.sv
// Bank of BINS single-pole IIR filters sharing one write port, with a
// snapshot-and-stream readout over a valid/ready channel.
module iir_bank_readout #(
    parameter int N        = 16,
    parameter int BINS     = 24,
    parameter int IIRCONST = 6
) (
    input logic            clk,
    input logic            rst,
    iir_bank_readout_if.slave bus
);
    localparam int BW = (BINS > 1) ? $clog2(BINS) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(BINS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic signed [N-1:0] r_live   [BINS];
    logic signed [N-1:0] r_shadow [BINS];
    logic [BW-1:0]       r_idx;

    logic                w_in_range;
    logic                w_snap;
    logic                w_xfer;
    logic signed [N-1:0] w_cur;
    logic signed [N-1:0] w_diff;
    logic signed [N-1:0] w_step;
    logic signed [N-1:0] w_upd;

    // Each intermediate is held in an N-bit signed net so it wraps before the shift.
    always_comb begin
        w_in_range = int'(bus.inBin) < BINS;
        w_cur      = w_in_range ? r_live[bus.inBin] : '0;
        w_diff     = bus.in - w_cur;
        w_step     = w_diff >>> IIRCONST;
        w_upd      = w_cur + w_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BINS; i++) r_live[i] <= '0;
        end else if (bus.write && w_in_range) begin
            r_live[bus.inBin] <= w_upd;
        end
    end

    assign w_snap = (r_state == IDLE) && bus.start;
    assign w_xfer = (r_state == SEND) && bus.outReady;

    // Index stays on the last bin after the final transfer; IDLE masks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BINS; i++) r_shadow[i] <= '0;
            r_idx <= '0;
        end else if (w_snap) begin
            for (int unsigned i = 0; i < BINS; i++) r_shadow[i] <= r_live[i];
            r_idx <= '0;
        end else if (w_xfer && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = SEND;
            SEND:    if (bus.outReady && (r_idx == LAST_IDX)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.outValid = 1'b0;
        bus.outLast  = 1'b0;
        bus.busy     = 1'b0;
        bus.outData  = '0;
        bus.outBin   = '0;
        if (r_state == SEND) begin
            bus.outValid = 1'b1;
            bus.busy     = 1'b1;
            bus.outData  = r_shadow[r_idx];
            bus.outBin   = r_idx;
            bus.outLast  = (r_idx == LAST_IDX);
        end
    end
endmodule
